bpu_gen2: RTL and testbench

- Parametrised next-generation branch prediction unit and fetch-PC generator; sits at the front of the fetch pipeline and drives the instruction-fetch address each cycle.
- Predicts a fetch block of FETCH_WIDTH aligned instructions per cycle using:
  - a tagged direct-mapped BTB;
  - a gshare PHT (global history XOR PC);
  - a circular RAS with checkpoint/restore of pointer and history on backend flush.

---
 rtl/bpu_gen2.sv | 192 +++++++++++++++++++
 tb/tb_bpu_gen2.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_gen2.sv
// Branch prediction unit and fetch-PC generator: tagged direct-mapped BTB,
// gshare PHT and a circular RAS with pointer/history restore on flush.
module bpu_gen2 #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned BTB_DEPTH   = 64,
  parameter int unsigned BTB_TAG_W   = 10,
  parameter int unsigned PHT_DEPTH   = 1024,
  parameter int unsigned GHR_W       = 8,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
  localparam int unsigned OFF_W      = $clog2(FETCH_WIDTH),
  localparam int unsigned SLOT_W     = (OFF_W == 0) ? 1 : OFF_W,
  localparam int unsigned RP         = $clog2(RAS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [31:0]            flush_pc_i,
  input  logic                   upd_valid_i,
  input  logic [31:0]            upd_pc_i,
  input  logic [31:0]            upd_target_i,
  input  logic [1:0]             upd_type_i,
  input  logic                   upd_taken_i,
  input  logic [GHR_W-1:0]       upd_ghr_i,
  input  logic [RP-1:0]          upd_ras_ptr_i,
  output logic [31:0]            pc_o,
  output logic [FETCH_WIDTH-1:0] fetch_valid_o,
  output logic                   pred_taken_o,
  output logic [SLOT_W-1:0]      pred_slot_o,
  output logic [31:0]            npc_o,
  output logic [GHR_W-1:0]       ghr_o,
  output logic [RP-1:0]          ras_ptr_o
);

  localparam int unsigned BI        = $clog2(BTB_DEPTH);
  localparam int unsigned PI        = $clog2(PHT_DEPTH);
  localparam int unsigned BLK_BYTES = FETCH_WIDTH * 4;
  localparam int unsigned IDX_SH    = OFF_W + 2;
  localparam int unsigned TAG_SH    = OFF_W + 2 + BI;
  localparam logic [1:0]  T_COND    = 2'd0;
  localparam logic [1:0]  T_CALL    = 2'd2;
  localparam logic [1:0]  T_RET     = 2'd3;

  typedef enum logic {S_REFILL, S_READY} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [RP-1:0]    ras_ptr_q, ras_ptr_d;

  logic                 btb_valid_q [BTB_DEPTH];
  logic [BTB_TAG_W-1:0] btb_tag_q   [BTB_DEPTH];
  logic [SLOT_W-1:0]    btb_slot_q  [BTB_DEPTH];
  logic [1:0]           btb_type_q  [BTB_DEPTH];
  logic [29:0]          btb_tgt_q   [BTB_DEPTH];
  logic [1:0]           pht_q       [PHT_DEPTH];
  logic [31:0]          ras_q       [RAS_DEPTH];

  // Lookup from the registered fetch PC
  logic [SLOT_W-1:0]    off_c, e_slot_c;
  logic [BI-1:0]        idx_c;
  logic [BTB_TAG_W-1:0] tag_c;
  logic [PI-1:0]        pht_idx_c;
  logic [1:0]           e_type_c;
  logic [31:0]          blk_base_c, ras_top_c;
  logic                 hit_c, taken_c, ready_c;

  assign off_c      = SLOT_W'((pc_q >> 2) & 32'(FETCH_WIDTH - 1));
  assign idx_c      = BI'(pc_q >> IDX_SH);
  assign tag_c      = BTB_TAG_W'(pc_q >> TAG_SH);
  assign pht_idx_c  = PI'(pc_q >> 2) ^ PI'(ghr_q);
  assign e_slot_c   = btb_slot_q[idx_c];
  assign e_type_c   = btb_type_q[idx_c];
  assign blk_base_c = pc_q & ~32'(BLK_BYTES - 1);
  assign ras_top_c  = ras_q[ras_ptr_q - RP'(1)];
  assign ready_c    = (state_q == S_READY);
  assign hit_c      = btb_valid_q[idx_c] && (btb_tag_q[idx_c] == tag_c) && (e_slot_c >= off_c);
  assign taken_c    = hit_c && ((e_type_c != T_COND) || pht_q[pht_idx_c][1]);

  assign pc_o      = pc_q;
  assign ghr_o     = ghr_q;
  assign ras_ptr_o = ras_ptr_q;

  // Prediction outputs; REFILL presents an empty block pointing at the held PC
  always_comb begin
    fetch_valid_o = '0;
    pred_taken_o  = 1'b0;
    pred_slot_o   = '0;
    npc_o         = pc_q;
    if (ready_c) begin
      npc_o = blk_base_c + 32'(BLK_BYTES);
      for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
        if ((SLOT_W'(i) >= off_c) && (!taken_c || (SLOT_W'(i) <= e_slot_c))) begin
          fetch_valid_o[i] = 1'b1;
        end
      end
      if (taken_c) begin
        pred_taken_o = 1'b1;
        pred_slot_o  = e_slot_c;
        npc_o        = (e_type_c == T_RET) ? ras_top_c : {btb_tgt_q[idx_c], 2'b00};
      end
    end
  end

  // Speculative state: flush wins over stall, REFILL always advances
  logic        ras_we;
  logic [31:0] ras_wdata;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ghr_d     = ghr_q;
    ras_ptr_d = ras_ptr_q;
    ras_we    = 1'b0;
    ras_wdata = blk_base_c + (32'(e_slot_c) << 2) + 32'd4;
    if (flush_i) begin
      state_d   = S_REFILL;
      pc_d      = flush_pc_i & ~32'h3;
      ghr_d     = upd_ghr_i;
      ras_ptr_d = upd_ras_ptr_i;
    end else if (state_q == S_REFILL) begin
      state_d = S_READY;
    end else if (!stall_i) begin
      pc_d = npc_o;
      if (hit_c && (e_type_c == T_COND)) begin
        ghr_d = GHR_W'({ghr_q, taken_c});
      end
      if (taken_c && (e_type_c == T_CALL)) begin
        ras_we    = 1'b1;
        ras_ptr_d = ras_ptr_q + RP'(1);
      end
      if (taken_c && (e_type_c == T_RET)) begin
        ras_ptr_d = ras_ptr_q - RP'(1);
      end
    end
  end

  // Resolved-branch training; PHT is indexed with the pre-outcome history
  logic [BI-1:0]        upd_idx;
  logic [BTB_TAG_W-1:0] upd_tag;
  logic [SLOT_W-1:0]    upd_slot;
  logic [PI-1:0]        upd_pht_idx;
  logic [1:0]           pht_old, pht_wdata;
  logic                 pht_we, btb_we;

  always_comb begin
    upd_idx     = BI'(upd_pc_i >> IDX_SH);
    upd_tag     = BTB_TAG_W'(upd_pc_i >> TAG_SH);
    upd_slot    = SLOT_W'((upd_pc_i >> 2) & 32'(FETCH_WIDTH - 1));
    upd_pht_idx = PI'(upd_pc_i >> 2) ^ PI'(upd_ghr_i >> 1);
    pht_old     = pht_q[upd_pht_idx];
    pht_wdata   = pht_old;
    if (upd_taken_i) begin
      if (pht_old != 2'd3) pht_wdata = pht_old + 2'd1;
    end else begin
      if (pht_old != 2'd0) pht_wdata = pht_old - 2'd1;
    end
    pht_we = upd_valid_i && (upd_type_i == T_COND);
    btb_we = upd_valid_i && (upd_taken_i || (upd_type_i != T_COND));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REFILL;
      pc_q      <= RESET_PC;
      ghr_q     <= '0;
      ras_ptr_q <= '0;
      for (int unsigned i = 0; i < BTB_DEPTH; i++) btb_valid_q[i] <= 1'b0;
      for (int unsigned i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'b01;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ghr_q     <= ghr_d;
      ras_ptr_q <= ras_ptr_d;
      if (btb_we) btb_valid_q[upd_idx] <= 1'b1;
      if (pht_we) pht_q[upd_pht_idx] <= pht_wdata;
    end
  end

  // Payload arrays are qualified by the valid bits and need no reset
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[upd_idx]  <= upd_tag;
      btb_slot_q[upd_idx] <= upd_slot;
      btb_type_q[upd_idx] <= upd_type_i;
      btb_tgt_q[upd_idx]  <= 30'(upd_target_i >> 2);
    end
    if (ras_we) ras_q[ras_ptr_q] <= ras_wdata;
  end

endmodule

// File: tb/tb_bpu_gen2.sv
// Bench for bpu_gen2: a table of per-cycle {inputs, expected outputs} rows is
// driven each cycle; expectations go through a queue to an output monitor.
module tb_bpu_gen2;

  localparam logic [31:0] R = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic [31:0] upd_target_i = '0;
  logic [1:0]  upd_type_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [7:0]  upd_ghr_i = '0;
  logic [2:0]  upd_ras_ptr_i = '0;
  logic [31:0] pc_o;
  logic [1:0]  fetch_valid_o;
  logic        pred_taken_o;
  logic [0:0]  pred_slot_o;
  logic [31:0] npc_o;
  logic [7:0]  ghr_o;
  logic [2:0]  ras_ptr_o;

  always #5 clk = ~clk;

  bpu_gen2 dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .upd_type_i(upd_type_i), .upd_taken_i(upd_taken_i), .upd_ghr_i(upd_ghr_i),
    .upd_ras_ptr_i(upd_ras_ptr_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
    .pred_taken_o(pred_taken_o), .pred_slot_o(pred_slot_o), .npc_o(npc_o),
    .ghr_o(ghr_o), .ras_ptr_o(ras_ptr_o)
  );

  typedef struct {
    logic [95:0] name;
    logic        rst, stall, flush;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc, utgt;
    logic [1:0]  utype;
    logic        ut;
    logic [7:0]  ughr;
    logic [2:0]  uptr;
    logic [31:0] e_pc;
    logic [1:0]  e_val;
    logic        e_tk;
    logic        e_sl;
    logic [31:0] e_npc;
    logic [7:0]  e_ghr;
    logic [2:0]  e_ptr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t ex(logic [95:0] n, logic [31:0] pc, logic [1:0] val, logic tk,
                              logic sl, logic [31:0] npc, logic [7:0] g, logic [2:0] p);
    vec_t x;
    x.name = n; x.rst = 1'b0; x.stall = 1'b0; x.flush = 1'b0; x.fpc = '0;
    x.uv = 1'b0; x.upc = '0; x.utgt = '0; x.utype = '0; x.ut = 1'b0; x.ughr = '0; x.uptr = '0;
    x.e_pc = pc; x.e_val = val; x.e_tk = tk; x.e_sl = sl; x.e_npc = npc; x.e_ghr = g; x.e_ptr = p;
    return x;
  endfunction

  function automatic vec_t w_stall(vec_t x);
    x.stall = 1'b1;
    return x;
  endfunction

  function automatic vec_t w_rst(vec_t x);
    x.rst = 1'b1;
    return x;
  endfunction

  function automatic vec_t w_flush(vec_t x, logic [31:0] pc, logic [7:0] g, logic [2:0] p);
    x.flush = 1'b1; x.fpc = pc; x.ughr = g; x.uptr = p;
    return x;
  endfunction

  function automatic vec_t w_upd(vec_t x, logic [31:0] pc, logic [31:0] tgt, logic [1:0] ty,
                                 logic tk, logic [7:0] g);
    x.uv = 1'b1; x.upc = pc; x.utgt = tgt; x.utype = ty; x.ut = tk; x.ughr = g;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    rst = x.rst; stall_i = x.stall; flush_i = x.flush; flush_pc_i = x.fpc;
    upd_valid_i = x.uv; upd_pc_i = x.upc; upd_target_i = x.utgt; upd_type_i = x.utype;
    upd_taken_i = x.ut; upd_ghr_i = x.ughr; upd_ras_ptr_i = x.uptr;
  endtask

  task automatic chk(input logic [95:0] n, input logic [95:0] f,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %0s.%0s got %h want %h", n, f, got, want);
    end
  endtask

  // Output monitor, sampled well after the negedge when inputs have settled
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      chk(e.name, "pc",    pc_o,                  e.e_pc);
      chk(e.name, "valid", 32'(fetch_valid_o),    32'(e.e_val));
      chk(e.name, "taken", 32'(pred_taken_o),     32'(e.e_tk));
      chk(e.name, "slot",  32'(pred_slot_o),      32'(e.e_sl));
      chk(e.name, "npc",   npc_o,                 e.e_npc);
      chk(e.name, "ghr",   32'(ghr_o),            32'(e.e_ghr));
      chk(e.name, "rasptr", 32'(ras_ptr_o),       32'(e.e_ptr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset, sequential fetch, flush with unaligned target, JUMP training
    tbl.push_back(w_rst(ex("rst", R, 2'b00, 1'b0, 1'b0, R, 8'h00, 3'd0)));
    tbl.push_back(ex("refill0", R, 2'b00, 1'b0, 1'b0, R, 8'h00, 3'd0));
    tbl.push_back(w_upd(ex("ready0", R, 2'b11, 1'b0, 1'b0, 32'h1c000008, 8'h00, 3'd0),
                        32'h1c000200, 32'h1c000400, 2'd1, 1'b1, 8'h00));
    tbl.push_back(w_flush(ex("seq", 32'h1c000008, 2'b11, 1'b0, 1'b0, 32'h1c000010, 8'h00, 3'd0),
                          32'h1c000107, 8'h00, 3'd0));
    tbl.push_back(ex("refill_f", 32'h1c000104, 2'b00, 1'b0, 1'b0, 32'h1c000104, 8'h00, 3'd0));
    tbl.push_back(w_flush(ex("off1", 32'h1c000104, 2'b10, 1'b0, 1'b0, 32'h1c000108, 8'h00, 3'd0),
                          32'h1c000200, 8'h00, 3'd0));
    tbl.push_back(ex("refill_j", 32'h1c000200, 2'b00, 1'b0, 1'b0, 32'h1c000200, 8'h00, 3'd0));
    tbl.push_back(ex("jump", 32'h1c000200, 2'b01, 1'b1, 1'b0, 32'h1c000400, 8'h00, 3'd0));
    // COND training under stall: three taken updates saturate at 3
    for (int k = 0; k < 3; k++)
      tbl.push_back(w_upd(w_stall(ex("train_t", 32'h1c000400, 2'b11, 1'b0, 1'b0, 32'h1c000408, 8'h00, 3'd0)),
                          32'h1c000500, 32'h1c000600, 2'd0, 1'b1, 8'h01));
    tbl.push_back(w_flush(ex("train_end", 32'h1c000400, 2'b11, 1'b0, 1'b0, 32'h1c000408, 8'h00, 3'd0),
                          32'h1c000500, 8'h00, 3'd0));
    tbl.push_back(ex("refill_c", 32'h1c000500, 2'b00, 1'b0, 1'b0, 32'h1c000500, 8'h00, 3'd0));
    tbl.push_back(w_upd(w_stall(ex("cond_sat", 32'h1c000500, 2'b01, 1'b1, 1'b0, 32'h1c000600, 8'h00, 3'd0)),
                        32'h1c000500, 32'h1c000600, 2'd0, 1'b0, 8'h00));
    tbl.push_back(ex("cond_w", 32'h1c000500, 2'b01, 1'b1, 1'b0, 32'h1c000600, 8'h00, 3'd0));
    tbl.push_back(w_upd(w_stall(ex("ghr_shift", 32'h1c000600, 2'b11, 1'b0, 1'b0, 32'h1c000608, 8'h01, 3'd0)),
                        32'h1c000500, 32'h1c000600, 2'd0, 1'b0, 8'h00));
    tbl.push_back(w_flush(ex("ghr_hold", 32'h1c000600, 2'b11, 1'b0, 1'b0, 32'h1c000608, 8'h01, 3'd0),
                          32'h1c000500, 8'h00, 3'd0));
    tbl.push_back(ex("refill_c2", 32'h1c000500, 2'b00, 1'b0, 1'b0, 32'h1c000500, 8'h00, 3'd0));
    // counter now 01: not-taken; drive it to 00, hold there, then one taken back to 01
    tbl.push_back(w_upd(w_stall(ex("cond_nt", 32'h1c000500, 2'b11, 1'b0, 1'b0, 32'h1c000508, 8'h00, 3'd0)),
                        32'h1c000500, 32'h1c000600, 2'd0, 1'b0, 8'h00));
    tbl.push_back(w_upd(w_stall(ex("cond_nt1", 32'h1c000500, 2'b11, 1'b0, 1'b0, 32'h1c000508, 8'h00, 3'd0)),
                        32'h1c000500, 32'h1c000600, 2'd0, 1'b0, 8'h00));
    tbl.push_back(w_upd(w_stall(ex("cond_nt2", 32'h1c000500, 2'b11, 1'b0, 1'b0, 32'h1c000508, 8'h00, 3'd0)),
                        32'h1c000500, 32'h1c000600, 2'd0, 1'b1, 8'h01));
    tbl.push_back(ex("clamp0", 32'h1c000500, 2'b11, 1'b0, 1'b0, 32'h1c000508, 8'h00, 3'd0));
    // CALL at 304 slot 1 -> RETURN at 718
    tbl.push_back(w_upd(w_stall(ex("post_nt", 32'h1c000508, 2'b11, 1'b0, 1'b0, 32'h1c000510, 8'h00, 3'd0)),
                        32'h1c000304, 32'h1c000718, 2'd2, 1'b1, 8'h00));
    tbl.push_back(w_upd(w_stall(ex("post_nt1", 32'h1c000508, 2'b11, 1'b0, 1'b0, 32'h1c000510, 8'h00, 3'd0)),
                        32'h1c000718, 32'h00000000, 2'd3, 1'b1, 8'h00));
    tbl.push_back(w_flush(ex("post_nt2", 32'h1c000508, 2'b11, 1'b0, 1'b0, 32'h1c000510, 8'h00, 3'd0),
                          32'h1c000304, 8'h00, 3'd0));
    tbl.push_back(ex("refill_cl", 32'h1c000304, 2'b00, 1'b0, 1'b0, 32'h1c000304, 8'h00, 3'd0));
    tbl.push_back(ex("call", 32'h1c000304, 2'b10, 1'b1, 1'b1, 32'h1c000718, 8'h00, 3'd0));
    tbl.push_back(ex("ret", 32'h1c000718, 2'b01, 1'b1, 1'b0, 32'h1c000308, 8'h00, 3'd1));
    tbl.push_back(w_flush(ex("after_ret", 32'h1c000308, 2'b11, 1'b0, 1'b0, 32'h1c000310, 8'h00, 3'd0),
                          32'h1c000304, 8'h00, 3'd3));
    tbl.push_back(ex("refill_p3", 32'h1c000304, 2'b00, 1'b0, 1'b0, 32'h1c000304, 8'h00, 3'd3));
    // five stalled cycles on a taken CALL, then flush while still stalled
    for (int k = 0; k < 5; k++)
      tbl.push_back(w_stall(ex("stall5", 32'h1c000304, 2'b10, 1'b1, 1'b1, 32'h1c000718, 8'h00, 3'd3)));
    tbl.push_back(w_flush(w_stall(ex("stall_fl", 32'h1c000304, 2'b10, 1'b1, 1'b1, 32'h1c000718, 8'h00, 3'd3)),
                          32'h1c000800, 8'h5a, 3'd6));
    tbl.push_back(ex("refill_rd", 32'h1c000800, 2'b00, 1'b0, 1'b0, 32'h1c000800, 8'h5a, 3'd6));
    tbl.push_back(w_flush(ex("redir", 32'h1c000800, 2'b11, 1'b0, 1'b0, 32'h1c000808, 8'h5a, 3'd6),
                          32'h1c000304, 8'h00, 3'd7));
    // RAS pointer wrap on push (7->0) and pop (0->7)
    tbl.push_back(ex("refill_p7", 32'h1c000304, 2'b00, 1'b0, 1'b0, 32'h1c000304, 8'h00, 3'd7));
    tbl.push_back(ex("call_wrap", 32'h1c000304, 2'b10, 1'b1, 1'b1, 32'h1c000718, 8'h00, 3'd7));
    tbl.push_back(ex("ret_wrap", 32'h1c000718, 2'b01, 1'b1, 1'b0, 32'h1c000308, 8'h00, 3'd0));
    tbl.push_back(w_flush(ex("ptr_back", 32'h1c000308, 2'b11, 1'b0, 1'b0, 32'h1c000310, 8'h00, 3'd7),
                          32'h1c000900, 8'h00, 3'd0));
    // async reset during REFILL clears BTB
    tbl.push_back(w_rst(ex("rst_mid", R, 2'b00, 1'b0, 1'b0, R, 8'h00, 3'd0)));
    tbl.push_back(w_rst(ex("rst_hold", R, 2'b00, 1'b0, 1'b0, R, 8'h00, 3'd0)));
    tbl.push_back(ex("refill_r", R, 2'b00, 1'b0, 1'b0, R, 8'h00, 3'd0));
    tbl.push_back(w_flush(ex("ready_r", R, 2'b11, 1'b0, 1'b0, 32'h1c000008, 8'h00, 3'd0),
                          32'h1c000200, 8'h00, 3'd0));
    tbl.push_back(ex("refill_b", 32'h1c000200, 2'b00, 1'b0, 1'b0, 32'h1c000200, 8'h00, 3'd0));
    tbl.push_back(ex("btb_clr", 32'h1c000200, 2'b11, 1'b0, 1'b0, 32'h1c000208, 8'h00, 3'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
    end

    for (int k = 0; k < 8; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #3;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
